// File: rtl/rpn_pkg.sv
// rpn_pkg: shared token kinds, opcodes, error codes and ASCII constants for the RPN front end
package rpn_pkg;
  typedef enum logic [1:0] {TOK_NUM = 2'b00, TOK_OP = 2'b01, TOK_EOL = 2'b10, TOK_ERR = 2'b11} tok_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_NUM, S_PEND} lex_state_e;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3, OP_MOD = 4'd4, OP_POW = 4'd5;
  localparam logic [1:0] ERR_BADCHAR = 2'd1, ERR_OVF = 2'd2;
  localparam logic [7:0] CH_0 = 8'h30, CH_9 = 8'h39, CH_SP = 8'h20, CH_TAB = 8'h09, CH_CR = 8'h0d, CH_LF = 8'h0a;
  localparam logic [7:0] CH_PLUS = 8'h2b, CH_MINUS = 8'h2d, CH_STAR = 8'h2a, CH_SLASH = 8'h2f, CH_PCT = 8'h25, CH_CARET = 8'h5e;
  function automatic logic [4:0] op_lookup(input logic [7:0] c);
    return c == CH_PLUS  ? {1'b1, OP_ADD} :
           c == CH_MINUS ? {1'b1, OP_SUB} :
           c == CH_STAR  ? {1'b1, OP_MUL} :
           c == CH_SLASH ? {1'b1, OP_DIV} :
           c == CH_PCT   ? {1'b1, OP_MOD} :
           c == CH_CARET ? {1'b1, OP_POW} : 5'd0;
  endfunction
endpackage

// File: rtl/token_fifo.sv
// token_fifo: first-word fall-through sync FIFO with wrap-bit pointers and zeroed output when empty
module token_fifo #(
  parameter int W = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign empty = wp == rp;
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  // advance pointers; a push into a full FIFO or a pop from an empty one is ignored
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  // storage is not reset: the read port is masked while empty
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/rpn_token_lexer.sv
// rpn_token_lexer: turns an ASCII byte stream into NUM/OP/EOL/ERR tokens queued in a small FIFO
module rpn_token_lexer import rpn_pkg::*; #(
  parameter int NUM_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [1:0]       tok_kind,
  output logic [NUM_W-1:0] tok_value
);
  localparam int TW = NUM_W + 2;
  lex_state_e state;
  logic [NUM_W-1:0] acc;
  logic ovf;
  logic [TW-1:0] pend_tok, num_tok, byte_tok, push_data, head;
  logic [NUM_W+3:0] wide;
  logic [4:0] op_hit;
  logic is_digit, is_sep, is_eol, is_op, accept, push, full, empty;
  assign in_ready = state != S_PEND && !full;
  // classify the byte, form candidate tokens and decide this cycle's single push
  always_comb begin
    op_hit = op_lookup(in_data);
    is_op = op_hit[4];
    is_digit = in_data >= CH_0 && in_data <= CH_9;
    is_sep = in_data == CH_SP || in_data == CH_TAB;
    is_eol = in_data == CH_CR || in_data == CH_LF;
    wide = {4'd0, acc} * (NUM_W+4)'(10) + (NUM_W+4)'(in_data[3:0]);
    num_tok = ovf ? {TOK_ERR, NUM_W'(ERR_OVF)} : {TOK_NUM, acc};
    byte_tok = is_op ? {TOK_OP, NUM_W'(op_hit[3:0])} : is_eol ? {TOK_EOL, NUM_W'(0)} : {TOK_ERR, NUM_W'(ERR_BADCHAR)};
    accept = in_valid && in_ready;
    push = state == S_PEND ? !full : accept && !is_digit && !(state == S_IDLE && is_sep);
    push_data = state == S_PEND ? pend_tok : state == S_NUM && (is_sep || is_op || is_eol) ? num_tok : byte_tok;
  end
  // lexer FSM: accumulator with sticky overflow, and the OP/EOL token held back behind a number
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      acc <= '0;
      ovf <= 1'b0;
      pend_tok <= '0;
    end else
      case (state)
        S_IDLE:
          if (accept && is_digit) begin
            acc <= NUM_W'(in_data[3:0]);
            ovf <= 1'b0;
            state <= S_NUM;
          end
        S_NUM:
          if (accept) begin
            acc <= is_digit ? wide[NUM_W-1:0] : '0;
            ovf <= is_digit && (ovf || wide[NUM_W+3:NUM_W] != 4'd0);
            pend_tok <= byte_tok;
            state <= is_digit ? S_NUM : (is_op || is_eol) ? S_PEND : S_IDLE;
          end
        default:
          if (!full) state <= S_IDLE;
      endcase
  token_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(tok_ready),
    .din(push_data),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign tok_valid = !empty;
  assign {tok_kind, tok_value} = head;
endmodule
